// File: rtl/mux16_scan_ctrl_pkg.sv
// Shared types, sizes and index helpers for the 16:1 scan select sequencer.
package mux16_scan_ctrl_pkg;

  localparam int unsigned N_IN  = 16;
  localparam int unsigned SEL_W = 4;

  typedef logic [N_IN-1:0]  word_t;
  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // First index presented after an accept.
  function automatic sel_t start_idx(input bit msb_first);
    return msb_first ? sel_t'(N_IN - 1) : sel_t'(0);
  endfunction

  // Final index of a word; its strobe carries bit_last.
  function automatic sel_t end_idx(input bit msb_first);
    return msb_first ? sel_t'(0) : sel_t'(N_IN - 1);
  endfunction

endpackage

// File: rtl/mux16_scan_ctrl_if.sv
// Upstream word handshake plus the word/select pair that feeds the 16:1 mux.
interface mux16_scan_ctrl_if;
  import mux16_scan_ctrl_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  abort;
  word_t word;
  sel_t  sel;
  logic  bit_strobe;
  logic  bit_last;
  logic  busy;

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, word, sel, bit_strobe, bit_last, busy
  );

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, word, sel, bit_strobe, bit_last, busy
  );

endinterface

// File: rtl/mux16_scan_ctrl_dwell_counter.sv
// Counts the cycles one select value is held; tick flags the terminal cycle.
module dwell_counter #(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en & (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Holds an accepted 16-bit word and walks the mux select through all indices,
// dwelling DWELL cycles on each and strobing when the mux output is settled.
module mux16_scan_ctrl
  import mux16_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  mux16_scan_ctrl_if.slave bus
);

  if (DWELL == 0) begin : g_bad_dwell
    $error("mux16_scan_ctrl: DWELL must be at least 1");
  end

  localparam sel_t START = start_idx(MSB_FIRST);
  localparam sel_t LAST  = end_idx(MSB_FIRST);

  state_e state_q, state_d;
  sel_t   sel_q, sel_d;
  word_t  word_q, word_d;
  logic   rdy_en_q;
  logic   tick;
  logic   accept;
  logic   busy_c, strobe_c, last_c, ready_c;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.abort | accept),
    .en   (state_q == RUN),
    .tick (tick)
  );

  // State register; rdy_en_q keeps in_ready low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      word_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      word_q   <= word_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state: abort beats accept, accept beats the end-of-word return to IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    word_d  = word_q;
    if (bus.abort) begin
      state_d = IDLE;
      sel_d   = '0;
    end else if (accept) begin
      state_d = RUN;
      sel_d   = START;
      word_d  = bus.in_data;
    end else if (strobe_c) begin
      if (last_c) begin
        state_d = IDLE;
        sel_d   = '0;
      end else if (MSB_FIRST) begin
        sel_d = sel_q - SEL_W'(1);
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  // Outputs decoded from registered state; in_ready never looks at in_valid.
  always_comb begin
    busy_c   = (state_q == RUN);
    strobe_c = busy_c & tick;
    last_c   = strobe_c & (sel_q == LAST);
    ready_c  = rdy_en_q & ((state_q == IDLE) | last_c) & ~bus.abort;
  end

  assign accept         = bus.in_valid & ready_c;
  assign bus.in_ready   = ready_c;
  assign bus.word       = word_q;
  assign bus.sel        = sel_q;
  assign bus.bit_strobe = strobe_c;
  assign bus.bit_last   = last_c;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: three instances (DWELL 1/2/3), directed vectors,
// corner sequences and a randomized run against a positional reference model.
module tb_mux16_scan_ctrl;
  import mux16_scan_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux16_scan_ctrl_if b1 ();
  mux16_scan_ctrl_if b2 ();
  mux16_scan_ctrl_if b3 ();

  mux16_scan_ctrl #(.DWELL(1), .MSB_FIRST(1'b0)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux16_scan_ctrl #(.DWELL(2), .MSB_FIRST(1'b0)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mux16_scan_ctrl #(.DWELL(3), .MSB_FIRST(1'b1)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic  in_ready;
    word_t word;
    sel_t  sel;
    logic  strobe;
    logic  last;
    logic  busy;
  } obs_t;

  // Expected serial sequence: seq[15] is the first bit sampled.
  typedef struct {
    int          id;
    word_t       data;
    logic [15:0] seq;
  } vec_t;

  vec_t vecs [3];

  function automatic logic mux16_1(input word_t w, input sel_t s);
    return w[s];
  endfunction

  function automatic obs_t get_obs(input int id);
    obs_t o;
    case (id)
      1:       o = '{b1.in_ready, b1.word, b1.sel, b1.bit_strobe, b1.bit_last, b1.busy};
      2:       o = '{b2.in_ready, b2.word, b2.sel, b2.bit_strobe, b2.bit_last, b2.busy};
      default: o = '{b3.in_ready, b3.word, b3.sel, b3.bit_strobe, b3.bit_last, b3.busy};
    endcase
    return o;
  endfunction

  task automatic drive(input int id, input logic v, input word_t d, input logic a);
    case (id)
      1: begin b1.in_valid = v; b1.in_data = d; b1.abort = a; end
      2: begin b2.in_valid = v; b2.in_data = d; b2.abort = a; end
      default: begin b3.in_valid = v; b3.in_data = d; b3.abort = a; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single word: instance id has DWELL==id, MSB_FIRST only for id 3.
  task automatic run_vec(input vec_t v);
    int   dw;
    bit   msb;
    int   j;
    obs_t o;
    dw  = v.id;
    msb = (v.id == 3);
    @(negedge clk);
    drive(v.id, 1'b1, v.data, 1'b0);
    #1;
    o = get_obs(v.id);
    chk("vec_ready", 32'(o.in_ready), 32'd1);
    @(negedge clk);
    drive(v.id, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 16 * dw; c++) begin
      o = get_obs(v.id);
      j = (c - 1) / dw;
      chk("vec_busy", 32'(o.busy), 32'd1);
      chk("vec_sel", 32'(o.sel), 32'(msb ? 15 - j : j));
      chk("vec_strobe", 32'(o.strobe), 32'((c % dw) == 0));
      if ((c % dw) == 0) begin
        chk("vec_bit", 32'(mux16_1(o.word, o.sel)), 32'(v.seq[15 - j]));
        chk("vec_last", 32'(o.last), 32'(j == 15));
      end
      @(negedge clk);
    end
    o = get_obs(v.id);
    chk("vec_idle_busy", 32'(o.busy), 32'd0);
    chk("vec_idle_sel", 32'(o.sel), 32'd0);
    chk("vec_idle_strobe", 32'(o.strobe), 32'd0);
    chk("vec_idle_word", 32'(o.word), 32'(v.data));
    chk("vec_idle_ready", 32'(o.in_ready), 32'd1);
  endtask

  // Random traffic against a model that tracks cycles elapsed since accept.
  task automatic run_random(input int id, input int ncyc);
    int    dw;
    bit    msb;
    bit    active;
    word_t mword;
    int    t;
    int    exp_sel;
    bit    exp_strobe, exp_last, exp_ready;
    logic  v, a;
    word_t d;
    obs_t  o;
    dw     = id;
    msb    = (id == 3);
    active = 1'b0;
    mword  = '0;
    t      = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 29) == 0);
      d = word_t'($urandom);
      drive(id, v, d, a);
      #1;
      o          = get_obs(id);
      exp_sel    = active ? (msb ? 15 - (t - 1) / dw : (t - 1) / dw) : 0;
      exp_strobe = active && ((t % dw) == 0);
      exp_last   = exp_strobe && (t == 16 * dw);
      exp_ready  = (!active || exp_last) && !a;
      chk("rnd_busy", 32'(o.busy), 32'(active));
      chk("rnd_sel", 32'(o.sel), 32'(exp_sel));
      chk("rnd_word", 32'(o.word), 32'(mword));
      chk("rnd_strobe", 32'(o.strobe), 32'(exp_strobe));
      chk("rnd_last", 32'(o.last), 32'(exp_last));
      chk("rnd_ready", 32'(o.in_ready), 32'(exp_ready));
      if (exp_strobe) chk("rnd_bit", 32'(mux16_1(o.word, o.sel)), 32'(mword[exp_sel]));
      if (a) begin
        active = 1'b0;
      end else if (v && exp_ready) begin
        active = 1'b1;
        mword  = d;
        t      = 1;
      end else if (active) begin
        if (t == 16 * dw) active = 1'b0;
        else t++;
      end
    end
    @(negedge clk);
    drive(id, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t  o;
    int    j;
    word_t wexp;

    vecs[0] = '{1, 16'hF518, 16'b0001_1000_1010_1111};
    vecs[1] = '{3, 16'h8001, 16'b1000_0000_0000_0001};
    vecs[2] = '{2, 16'h1234, 16'b0010_1100_0100_1000};

    for (int id = 1; id <= 3; id++) drive(id, 1'b0, '0, 1'b0);
    #2;
    for (int id = 1; id <= 3; id++) begin
      o = get_obs(id);
      chk("rst_sel", 32'(o.sel), 32'd0);
      chk("rst_word", 32'(o.word), 32'd0);
      chk("rst_busy", 32'(o.busy), 32'd0);
      chk("rst_strobe", 32'(o.strobe), 32'd0);
      chk("rst_ready", 32'(o.in_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int id = 1; id <= 3; id++) begin
      o = get_obs(id);
      chk("post_rst_ready", 32'(o.in_ready), 32'd1);
    end

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Back-to-back words on DWELL=1: 32 strobes in 32 cycles.
    @(negedge clk);
    drive(1, 1'b1, 16'hAAAA, 1'b0);
    @(negedge clk);
    for (int c = 1; c <= 32; c++) begin
      o    = get_obs(1);
      j    = (c - 1) % 16;
      wexp = (c <= 16) ? 16'hAAAA : 16'h5555;
      chk("b2b_strobe", 32'(o.strobe), 32'd1);
      chk("b2b_sel", 32'(o.sel), 32'(j));
      chk("b2b_word", 32'(o.word), 32'(wexp));
      chk("b2b_bit", 32'(mux16_1(o.word, o.sel)), 32'(wexp[j]));
      chk("b2b_last", 32'(o.last), 32'(j == 15));
      chk("b2b_ready", 32'(o.in_ready), 32'(j == 15));
      if (c == 1) drive(1, 1'b1, 16'h5555, 1'b0);
      if (c == 17) drive(1, 1'b0, '0, 1'b0);
      @(negedge clk);
    end
    o = get_obs(1);
    chk("b2b_idle_busy", 32'(o.busy), 32'd0);
    chk("b2b_idle_sel", 32'(o.sel), 32'd0);

    // Abort on the 6th strobe with in_valid high (DWELL=2).
    @(negedge clk);
    drive(2, 1'b1, 16'h0F0F, 1'b0);
    @(negedge clk);
    drive(2, 1'b0, '0, 1'b0);
    repeat (11) @(negedge clk);
    o = get_obs(2);
    chk("abt_strobe6", 32'(o.strobe), 32'd1);
    chk("abt_sel6", 32'(o.sel), 32'd5);
    drive(2, 1'b1, 16'h1357, 1'b1);
    #1;
    o = get_obs(2);
    chk("abt_ready", 32'(o.in_ready), 32'd0);
    @(negedge clk);
    o = get_obs(2);
    chk("abt_busy", 32'(o.busy), 32'd0);
    chk("abt_sel", 32'(o.sel), 32'd0);
    chk("abt_strobe", 32'(o.strobe), 32'd0);
    chk("abt_word_kept", 32'(o.word), 32'h0F0F);
    drive(2, 1'b1, 16'h2468, 1'b0);
    #1;
    o = get_obs(2);
    chk("abt_ready_after", 32'(o.in_ready), 32'd1);
    @(negedge clk);
    o = get_obs(2);
    chk("abt_new_busy", 32'(o.busy), 32'd1);
    chk("abt_new_word", 32'(o.word), 32'h2468);
    chk("abt_new_sel", 32'(o.sel), 32'd0);
    drive(2, 1'b0, '0, 1'b0);

    // Reset pulse mid-word after 5 bits (DWELL=2).
    repeat (10) @(negedge clk);
    o = get_obs(2);
    chk("mid_sel5", 32'(o.sel), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    o = get_obs(2);
    chk("mid_rst_sel", 32'(o.sel), 32'd0);
    chk("mid_rst_word", 32'(o.word), 32'd0);
    chk("mid_rst_busy", 32'(o.busy), 32'd0);
    chk("mid_rst_strobe", 32'(o.strobe), 32'd0);
    chk("mid_rst_last", 32'(o.last), 32'd0);
    chk("mid_rst_ready", 32'(o.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      o = get_obs(2);
      chk("post_mid_strobe", 32'(o.strobe), 32'd0);
      chk("post_mid_busy", 32'(o.busy), 32'd0);
      chk("post_mid_ready", 32'(o.in_ready), 32'd1);
    end

    run_random(1, 400);
    run_random(3, 400);
    run_random(2, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
